// File: rtl/ahblite_gpio_irq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ahblite_gpio_irq                                              |
// | Brief    : AHB-Lite GPIO slave: atomic set/clear/toggle, byte lanes,     |
// |            synchronised inputs, per-pin edge interrupts (GPIO_IRQ_EN).   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ahblite_gpio_irq #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [31:0] OUT_RST = 32'h0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic [3:0]       HPROT,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic [31:0]      HRDATA,
    output logic [WIDTH-1:0] outEn,
    output logic [WIDTH-1:0] oData,
    input  logic [WIDTH-1:0] iData,
    output logic             irq
);

    localparam logic [3:0] c_A_DATA_IN    = 4'd0;
    localparam logic [3:0] c_A_OUT_EN     = 4'd1;
    localparam logic [3:0] c_A_DATA_OUT   = 4'd2;
    localparam logic [3:0] c_A_OUT_SET    = 4'd3;
    localparam logic [3:0] c_A_OUT_CLR    = 4'd4;
    localparam logic [3:0] c_A_OUT_TGL    = 4'd5;
    localparam logic [3:0] c_A_IRQ_EN     = 4'd6;
    localparam logic [3:0] c_A_IRQ_RISE   = 4'd7;
    localparam logic [3:0] c_A_IRQ_FALL   = 4'd8;
    localparam logic [3:0] c_A_IRQ_STATUS = 4'd9;

    logic             r_act;
    logic             r_write;
    logic [3:0]       r_addr;
    logic [2:0]       r_size;
    logic [1:0]       r_lo;
    logic [WIDTH-1:0] r_out_en;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    logic [3:0]       w_be;
    logic [31:0]      w_bmask;
    logic [31:0]      w_wd;
    logic [WIDTH-1:0] w_wd_n;
    logic [WIDTH-1:0] w_bm_n;
    logic             w_wr;
    logic [WIDTH-1:0] w_dout_nx;
    logic [31:0]      w_rd;
    logic             w_unused;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign w_unused  = ^{HPROT, HADDR[31:6], HTRANS[0], w_wd};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_act   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 4'd0;
            r_size  <= 3'd0;
            r_lo    <= 2'd0;
        end else if (HREADY) begin
            r_act   <= HSEL & HTRANS[1];
            r_write <= HWRITE;
            r_addr  <= HADDR[5:2];
            r_size  <= HSIZE;
            r_lo    <= HADDR[1:0];
        end
    end

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            3'b000:  w_be = 4'b0001 << r_lo;
            3'b001:  w_be = r_lo[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Masked write data doubles as the "unused lanes act as 0" operand for SET/CLR/TGL/W1C
    assign w_bmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_wd    = HWDATA & w_bmask;
    assign w_wd_n  = w_wd[WIDTH-1:0];
    assign w_bm_n  = w_bmask[WIDTH-1:0];
    assign w_wr    = r_act & r_write;

    always_comb begin
        w_dout_nx = r_data_out;
        if (w_wr) begin
            case (r_addr)
                c_A_DATA_OUT: w_dout_nx = (r_data_out & ~w_bm_n) | w_wd_n;
                c_A_OUT_SET:  w_dout_nx = r_data_out | w_wd_n;
                c_A_OUT_CLR:  w_dout_nx = r_data_out & ~w_wd_n;
                c_A_OUT_TGL:  w_dout_nx = r_data_out ^ w_wd_n;
                default:      w_dout_nx = r_data_out;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_out_en   <= '0;
            r_data_out <= OUT_RST[WIDTH-1:0];
            r_s1       <= '0;
            r_s2       <= '0;
        end else begin
            if (w_wr && r_addr == c_A_OUT_EN)
                r_out_en <= (r_out_en & ~w_bm_n) | w_wd_n;
            r_data_out <= w_dout_nx;
            r_s1       <= iData;
            r_s2       <= r_s1;
        end
    end

    assign outEn = r_out_en;
    assign oData = r_data_out;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_irq_rise;
    logic [WIDTH-1:0] r_irq_fall;
    logic [WIDTH-1:0] r_irq_status;
    logic             r_irq;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_w1c;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_w1c  = (w_wr && r_addr == c_A_IRQ_STATUS) ? w_wd_n : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_s3         <= '0;
            r_irq_en     <= '0;
            r_irq_rise   <= '0;
            r_irq_fall   <= '0;
            r_irq_status <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_s3 <= r_s2;
            if (w_wr && r_addr == c_A_IRQ_EN)
                r_irq_en <= (r_irq_en & ~w_bm_n) | w_wd_n;
            if (w_wr && r_addr == c_A_IRQ_RISE)
                r_irq_rise <= (r_irq_rise & ~w_bm_n) | w_wd_n;
            if (w_wr && r_addr == c_A_IRQ_FALL)
                r_irq_fall <= (r_irq_fall & ~w_bm_n) | w_wd_n;
            // Hardware set is OR-ed after the clear so it wins a same-cycle W1C
            r_irq_status <= (r_irq_status & ~w_w1c) | (w_rise & r_irq_rise) | (w_fall & r_irq_fall);
            r_irq        <= |(r_irq_status & r_irq_en);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd = 32'h0;
        case (r_addr)
            c_A_DATA_IN:    w_rd = 32'(r_s2);
            c_A_OUT_EN:     w_rd = 32'(r_out_en);
            c_A_DATA_OUT:   w_rd = 32'(r_data_out);
`ifdef GPIO_IRQ_EN
            c_A_IRQ_EN:     w_rd = 32'(r_irq_en);
            c_A_IRQ_RISE:   w_rd = 32'(r_irq_rise);
            c_A_IRQ_FALL:   w_rd = 32'(r_irq_fall);
            c_A_IRQ_STATUS: w_rd = 32'(r_irq_status);
`endif
            default:        w_rd = 32'h0;
        endcase
    end

    assign HRDATA = (r_act & ~r_write) ? w_rd : 32'h0;

endmodule
`default_nettype wire
